// File: rtl/lockstep_pkg.sv
// Shared definitions for the dual-core lockstep controller.
// The optional LOCKSTEP_PERF_EN build adds a RUN-cycle counter in the top.
package lockstep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HALT   = 3'd1,
        ST_SYNC   = 3'd2,
        ST_RESUME = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAULT  = 3'd5
    } lockstep_state_e;

    // Lockstep control register location and its enable bit.
    localparam logic [31:0] LOCKSTEP_ADDRESS = 32'h10204400;
    localparam int          LOCKSTEP_EN_BIT  = 0;

endpackage

// File: rtl/lockstep_timeout_cnt.sv
// Halt-acknowledge timeout counter. It counts while enabled and flags
// expiry on the last cycle of a window of `limit` cycles.
// A limit of zero disables expiry entirely.
module lockstep_timeout_cnt
    import lockstep_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr,
    input  logic                 en,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] cnt_q;

    // Count up while enabled; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (limit != '0) && (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/lockstep_sequencer.sv
// Lockstep entry sequencer: halts both cores, pulses a synchronous reset,
// resumes them, then watches the comparator. Counted mismatches re-enter
// lockstep until the retry budget is spent, then the block parks in FAULT.
// Build option: define LOCKSTEP_PERF_EN to count cycles spent in RUN.
// All outputs come from the state register or other flops.
module lockstep_sequencer
    import lockstep_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int ERR_CNT_W = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
    input  logic                 clr_err_i,
    input  logic [1:0]           halted_i,
    input  logic                 cmp_valid_i,
    input  logic                 cmp_mismatch_i,
    output logic [1:0]           halt_req_o,
    output logic                 sync_rst_o,
    output logic                 resume_o,
    output logic                 active_o,
    output logic                 err_irq_o,
    output logic                 fault_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [2:0]           state_o,
    output logic [31:0]          run_cycles_o
);

    localparam logic [ERR_CNT_W-1:0] MAX_RETRY_C = ERR_CNT_W'(MAX_RETRY);

    lockstep_state_e        state_q, state_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_inc;
    logic                   err_irq_q;
    logic                   mismatch_hit;
    logic                   timer_expired;

    // Timer restarts whenever we are outside HALT, so it reads 0 on entry.
    lockstep_timeout_cnt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (state_q != ST_HALT),
        .en      (state_q == ST_HALT),
        .limit   (timeout_cfg_i),
        .expired (timer_expired)
    );

    assign mismatch_hit = (state_q == ST_RUN) && cmp_valid_i && cmp_mismatch_i;
    assign err_inc      = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; the retry decision uses the pre-clear count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_HALT;
            ST_HALT: begin
                if (!enable_i)               state_d = ST_IDLE;
                else if (halted_i == 2'b11)  state_d = ST_SYNC;
                else if (timer_expired)      state_d = ST_FAULT;
            end
            ST_SYNC:   state_d = ST_RESUME;
            ST_RESUME: state_d = ST_RUN;
            ST_RUN: begin
                if (mismatch_hit)  state_d = (err_inc >= MAX_RETRY_C) ? ST_FAULT : ST_HALT;
                else if (!enable_i) state_d = ST_IDLE;
            end
            ST_FAULT:  if (clr_err_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Mismatch counter and its interrupt pulse; clear beats a same-cycle count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
            err_irq_q <= 1'b0;
        end else begin
            err_irq_q <= mismatch_hit;
            if (clr_err_i)         err_cnt_q <= '0;
            else if (mismatch_hit) err_cnt_q <= err_inc;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        halt_req_o = 2'b00;
        sync_rst_o = 1'b0;
        resume_o   = 1'b0;
        active_o   = 1'b0;
        fault_o    = 1'b0;
        case (state_q)
            ST_HALT:   halt_req_o = 2'b11;
            ST_SYNC: begin
                halt_req_o = 2'b11;
                sync_rst_o = 1'b1;
            end
            ST_RESUME: resume_o = 1'b1;
            ST_RUN:    active_o = 1'b1;
            ST_FAULT: begin
                halt_req_o = 2'b11;
                fault_o    = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_irq_o = err_irq_q;
    assign err_cnt_o = err_cnt_q;
    assign state_o   = state_q;

`ifdef LOCKSTEP_PERF_EN
    logic [31:0] run_cnt_q;

    // RUN-cycle counter: wraps naturally, holds outside RUN, cleared with errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q <= '0;
        end else if (clr_err_i) begin
            run_cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            run_cnt_q <= run_cnt_q + 32'd1;
        end
    end

    assign run_cycles_o = run_cnt_q;
`else
    assign run_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_lockstep_sequencer.sv
// Self-checking bench for lockstep_sequencer. The driver applies inputs on
// the falling edge, advances a behavioural model and queues the outputs the
// DUT must show after the next rising edge; a monitor pops and compares.
module tb_lockstep_sequencer;

    localparam int W         = 50;
    localparam int MAX_RETRY = 3;

    localparam int S_IDLE = 0, S_HALT = 1, S_SYNC = 2, S_RESUME = 3, S_RUN = 4, S_FAULT = 5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [7:0]  timeout_cfg_i = '0;
    logic        clr_err_i = 1'b0;
    logic [1:0]  halted_i = '0;
    logic        cmp_valid_i = 1'b0;
    logic        cmp_mismatch_i = 1'b0;
    logic [1:0]  halt_req_o;
    logic        sync_rst_o, resume_o, active_o, err_irq_o, fault_o;
    logic [7:0]  err_cnt_o;
    logic [2:0]  state_o;
    logic [31:0] run_cycles_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model state.
    int          m_state;
    int          m_halt_cycles;
    int          m_err;
    bit          m_irq;
    logic [31:0] m_run;

    lockstep_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .timeout_cfg_i  (timeout_cfg_i),
        .clr_err_i      (clr_err_i),
        .halted_i       (halted_i),
        .cmp_valid_i    (cmp_valid_i),
        .cmp_mismatch_i (cmp_mismatch_i),
        .halt_req_o     (halt_req_o),
        .sync_rst_o     (sync_rst_o),
        .resume_o       (resume_o),
        .active_o       (active_o),
        .err_irq_o      (err_irq_o),
        .fault_o        (fault_o),
        .err_cnt_o      (err_cnt_o),
        .state_o        (state_o),
        .run_cycles_o   (run_cycles_o)
    );

    // Clock and reset.
    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] dut_vec();
        return {state_o, halt_req_o, sync_rst_o, resume_o, active_o,
                err_irq_o, fault_o, err_cnt_o, run_cycles_o};
    endfunction

    // Expected output vector from the model's current situation.
    function automatic logic [W-1:0] model_vec();
        logic [2:0] st;
        logic [1:0] hr;
        st = 3'(m_state);
        hr = (m_state == S_HALT || m_state == S_SYNC || m_state == S_FAULT) ? 2'b11 : 2'b00;
        return {st, hr, 1'(m_state == S_SYNC), 1'(m_state == S_RESUME),
                1'(m_state == S_RUN), 1'(m_irq), 1'(m_state == S_FAULT),
                8'(m_err), m_run};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_halt_cycles = 0;
        m_err = 0;
        m_irq = 0;
        m_run = '0;
    endtask

    // One clock of the lockstep rules applied to the current inputs.
    task automatic model_step();
        int  nxt;
        bit  hit;
        int  bumped;
        nxt    = m_state;
        hit    = (m_state == S_RUN) && cmp_valid_i && cmp_mismatch_i;
        bumped = (m_err == 255) ? 255 : m_err + 1;
        if (m_state == S_IDLE) begin
            if (enable_i) nxt = S_HALT;
        end else if (m_state == S_HALT) begin
            // m_halt_cycles = number of HALT cycles already completed.
            if (!enable_i) nxt = S_IDLE;
            else if (halted_i == 2'b11) nxt = S_SYNC;
            else if (timeout_cfg_i != 0 && m_halt_cycles + 1 == int'(timeout_cfg_i)) nxt = S_FAULT;
        end else if (m_state == S_SYNC) begin
            nxt = S_RESUME;
        end else if (m_state == S_RESUME) begin
            nxt = S_RUN;
        end else if (m_state == S_RUN) begin
            if (hit) nxt = (bumped >= MAX_RETRY) ? S_FAULT : S_HALT;
            else if (!enable_i) nxt = S_IDLE;
        end else if (m_state == S_FAULT) begin
            if (clr_err_i) nxt = S_IDLE;
        end
`ifdef LOCKSTEP_PERF_EN
        if (clr_err_i) m_run = '0;
        else if (m_state == S_RUN) m_run = m_run + 32'd1;
`endif
        if (clr_err_i) m_err = 0;
        else if (hit) m_err = bumped;
        m_irq = hit;
        m_halt_cycles = (m_state == S_HALT && nxt == S_HALT) ? m_halt_cycles + 1 : 0;
        m_state = nxt;
    endtask

    // Driver: apply inputs at the current (falling) edge and queue expectation.
    task automatic apply(input bit en, input logic [7:0] tcfg, input bit clr,
                         input logic [1:0] hal, input bit cv, input bit cm);
        enable_i       = en;
        timeout_cfg_i  = tcfg;
        clr_err_i      = clr;
        halted_i       = hal;
        cmp_valid_i    = cv;
        cmp_mismatch_i = cm;
        model_step();
        exp_q.push_back(model_vec());
    endtask

    task automatic drive(input bit en, input logic [7:0] tcfg, input bit clr,
                         input logic [1:0] hal, input bit cv, input bit cm);
        @(negedge clk_i);
        apply(en, tcfg, clr, hal, cv, cm);
    endtask

    // Asynchronous reset mid-flight: outputs must clear before any clock edge.
    task automatic rst_pulse();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (dut_vec() != '0) begin
            tests_failed++;
            $display("FAIL async_reset got %h exp 0", dut_vec());
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(1'b0, timeout_cfg_i, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compare one expectation after each rising edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                tests_run++;
                if (dut_vec() !== e) begin
                    tests_failed++;
                    $display("FAIL outputs t=%0t got %h exp %h (state %0d/%0d err %0d/%0d)",
                             $time, dut_vec(), e, state_o, e[W-1 -: 3], err_cnt_o, e[39:32]);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        model_reset();
        #3;
        tests_run++;
        if (dut_vec() != '0) begin
            tests_failed++;
            $display("FAIL reset_state got %h exp 0", dut_vec());
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Entry with acks already high.
        repeat (6) drive(1, 8'd0, 0, 2'b11, 0, 0);
        // Unqualified mismatch must be ignored.
        repeat (10) drive(1, 8'd0, 0, 2'b11, 0, 1);
        // Three counted mismatches: two retries, then FAULT.
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'd0, 0, 2'b11, 1, 1);
            repeat (6) drive(1, 8'd0, 0, 2'b11, 0, 0);
        end
        // Enable ignored in FAULT; clear exits.
        repeat (2) drive(0, 8'd0, 0, 2'b11, 0, 0);
        drive(0, 8'd0, 1, 2'b11, 0, 0);
        repeat (2) drive(0, 8'd0, 0, 2'b00, 0, 0);
        // Halt-ack timeout of 5 cycles, then clear.
        repeat (9) drive(1, 8'd5, 0, 2'b00, 0, 0);
        drive(0, 8'd5, 1, 2'b00, 0, 0);
        repeat (2) drive(0, 8'd5, 0, 2'b00, 0, 0);
        // Abort during HALT with partial acks.
        repeat (3) drive(1, 8'd0, 0, 2'b01, 0, 0);
        repeat (3) drive(0, 8'd0, 0, 2'b01, 0, 0);
        // Mismatch together with enable drop, and clear together with mismatch.
        repeat (5) drive(1, 8'd0, 0, 2'b11, 0, 0);
        drive(0, 8'd0, 0, 2'b11, 1, 1);
        repeat (2) drive(0, 8'd0, 0, 2'b11, 0, 0);
        repeat (5) drive(1, 8'd0, 0, 2'b11, 0, 0);
        drive(1, 8'd0, 1, 2'b11, 1, 1);
        repeat (6) drive(1, 8'd0, 0, 2'b11, 0, 0);
        // Reach RUN with two counted errors, then reset.
        for (int k = 0; k < 2; k++) begin
            drive(1, 8'd0, 0, 2'b11, 1, 1);
            repeat (6) drive(1, 8'd0, 0, 2'b11, 0, 0);
        end
        rst_pulse();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] tcfg;
            logic [1:0] hal;
            tcfg = timeout_cfg_i;
            if ($urandom_range(0, 19) == 0) tcfg = 8'($urandom_range(0, 8));
            hal = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                rst_pulse();
            end else begin
                drive($urandom_range(0, 99) < 92, tcfg, $urandom_range(0, 99) < 3, hal,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 15);
            end
        end

        @(posedge clk_i);
        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lockstep_sequencer.md
Name: lockstep_sequencer

Overview:
- Controller for the dual-core lockstep pair behind the lockstep control register.
- Takes the register's enable bit and the comparator's result stream, and sequences lockstep entry: halt both cores, synchronous reset, resume.
- Monitors mismatches and counts them; re-enters lockstep on error until a retry budget is exhausted, then parks in a sticky FAULT state.
- Sits beside the peripheral register slave in the cluster peripheral domain.

Parameters:
- TIMEOUT_W, 8: width of halt-acknowledge timeout counter and timeout_cfg_i.
- ERR_CNT_W, 8: width of the saturating mismatch counter.
- MAX_RETRY, 3: mismatch count at which FAULT is entered instead of a retry (1..2^ERR_CNT_W-1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  lockstep enable, level, from control register bit 0.
- timeout_cfg_i  in  TIMEOUT_W  halt-ack timeout in cycles; 0 disables timeout.
- clr_err_i  in  1  pulse; clears error counter; exits FAULT.
- halted_i  in  2  per-core halted acknowledge, level.
- cmp_valid_i  in  1  comparator result valid this cycle.
- cmp_mismatch_i  in  1  comparator mismatch; qualified by cmp_valid_i.
- halt_req_o  out  2  per-core halt request.
- sync_rst_o  out  1  one-cycle synchronous core reset.
- resume_o  out  1  one-cycle resume pulse.
- active_o  out  1  lockstep running.
- err_irq_o  out  1  one-cycle pulse per counted mismatch.
- fault_o  out  1  sticky fault.
- err_cnt_o  out  ERR_CNT_W  mismatch count.
- state_o  out  3  current state encoding.
- run_cycles_o  out  32  RUN cycle count (optional feature).

Behaviour:
- Reset: state IDLE; all outputs 0; err_cnt, timer and run counter 0.
- States and encodings: IDLE=0, HALT=1, SYNC=2, RESUME=3, RUN=4, FAULT=5. Unused encodings go to IDLE.
- All outputs are decoded from the registered state or taken from registers. No combinational path from any input to any output.
- IDLE:
  - Outputs idle.
  - enable_i=1 → HALT.
- HALT:
  - halt_req_o=2'b11.
  - Timer clears on entry and increments each cycle.
  - enable_i=0 → IDLE; this takes priority over every other exit.
  - Else halted_i==2'b11 → SYNC.
  - Else timeout_cfg_i!=0 and timer==timeout_cfg_i-1 → FAULT.
  - Acks arriving in the same cycle the timeout is reached: ack wins.
- SYNC:
  - Exactly 1 cycle.
  - sync_rst_o=1, halt_req_o=2'b11.
  - → RESUME unconditionally; enable_i is ignored.
- RESUME:
  - Exactly 1 cycle.
  - resume_o=1, halt_req_o=0.
  - → RUN unconditionally.
- RUN:
  - active_o=1.
  - cmp_valid_i && cmp_mismatch_i:
    - err_cnt increments, saturating at all-ones.
    - err_irq_o=1 the next cycle.
    - If the incremented count is >= MAX_RETRY → FAULT, else → HALT.
  - Otherwise enable_i=0 → IDLE.
  - Mismatch and enable_i=0 in the same cycle: the mismatch is counted and goes to HALT, and HALT then exits to IDLE.
  - cmp_mismatch_i without cmp_valid_i is ignored.
- FAULT:
  - fault_o=1, halt_req_o=2'b11, active_o=0.
  - Only clr_err_i exits, → IDLE; enable_i is ignored.
- clr_err_i:
  - Clears err_cnt in any state.
  - If a counted mismatch occurs in the same cycle, the clear wins and err_cnt becomes 0. The state transition from that mismatch still uses the pre-clear incremented count.
- Latency: enable_i rise to active_o is 4 cycles minimum (IDLE→HALT, acks already high, →SYNC→RESUME→RUN).
- Asynchronous reset mid-sequence returns to IDLE immediately. halt_req_o drops asynchronously.

Optional Feature:
- Macro: LOCKSTEP_PERF_EN.
- Defined:
  - 32-bit run_cycles_o increments every cycle in RUN and wraps at 2^32.
  - Cleared by clr_err_i.
  - Holds its value outside RUN.
- Undefined: run_cycles_o tied to 0 and no counter flops are instantiated.

Decomposition:
- Package lockstep_pkg holds:
  - lockstep_state_e enum with the encodings above.
  - LOCKSTEP_ADDRESS constant (32'h10204400).
  - Enable bit index constant (0).
- Sub-module lockstep_timeout_cnt:
  - Parameterised TIMEOUT_W counter.
  - Ports: clr, en, limit, expired.
  - Expired is never asserted when limit==0.

Test Plan:
- Entry:
  - Stimulus: enable_i=1, halted_i tied 2'b11.
  - Required: halt_req_o=11 at cycle 1, sync_rst_o at cycle 2, resume_o at cycle 3, active_o=1 at cycle 4, state_o=4.
- Timeout:
  - Stimulus: timeout_cfg_i=5, halted_i=00, enable_i=1.
  - Required: FAULT after exactly 5 HALT cycles; fault_o=1; halt_req_o stays 11.
  - Follow-up: clr_err_i pulse → IDLE, fault_o=0.
- Retry:
  - Stimulus: MAX_RETRY=3; in RUN, three single mismatch pulses with prompt acks.
  - Required: err_irq_o pulses 3 times; err_cnt_o=1,2,3; re-sequenced twice through HALT/SYNC/RESUME; FAULT after the third.
- Qualification:
  - Stimulus: cmp_mismatch_i=1 with cmp_valid_i=0 for 10 cycles in RUN.
  - Required: err_cnt_o stays 0; state stays RUN.
- Abort:
  - Stimulus: enable_i drops during HALT with acks partial (01).
  - Required: IDLE next cycle; halt_req_o=00; no sync_rst_o pulse.
- Reset in RUN:
  - Stimulus: rst_ni asserted in RUN with err_cnt=2.
  - Required: all outputs 0 and state_o=0 immediately. With LOCKSTEP_PERF_EN, run_cycles_o=0.
